// File: rtl/ufix_to_fp32_pipe.sv
// ufix_to_fp32_pipe
//   Two-stage pipelined converter from unsigned fixed point UQ(IN_W-FRAC_W).FRAC_W
//   to IEEE-754 single precision, round to nearest / ties to even.
//   S1 captures the operand, a zero flag and the leading-one index k.
//   S2 captures the normalized, rounded and assembled float.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   in_data      : IN_W-bit unsigned fixed-point operand
//   in_valid     : in_data valid
//   in_ready     : converter accepts an operand this cycle
//   out_fp32     : single-precision result (sign always 0)
//   out_inexact  : rounding dropped nonzero bits
//   out_valid    : out_fp32/out_inexact valid
//   out_ready    : downstream accepts the result this cycle
module ufix_to_fp32_pipe #(
  parameter int IN_W   = 16,
  parameter int FRAC_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [31:0]     out_fp32,
  output logic            out_inexact,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam int KW = (IN_W > 1) ? $clog2(IN_W) : 1;
  // Biased exponent of a leading one at bit 0, minus one. The hidden bit of
  // the mantissa is added into the exponent field during assembly, which
  // restores the missing one and also absorbs any rounding carry for free.
  localparam logic [7:0] EXP_M1 = 8'(126 - FRAC_W);

  // ---------------------------------------------------------------------------
  // Handshake / valid pipeline
  // ---------------------------------------------------------------------------
  logic [2:1] vld_pipe_q, vld_pipe_d;
  logic       s2_load;

  // S2 can take a new value when empty or being drained this cycle.
  assign s2_load  = !vld_pipe_q[2] || out_ready;
  assign in_ready = !vld_pipe_q[1] || s2_load;

  always_comb begin
    vld_pipe_d    = vld_pipe_q;
    if (in_ready) vld_pipe_d[1] = in_valid;
    if (s2_load)  vld_pipe_d[2] = vld_pipe_q[1];
  end

  // ---------------------------------------------------------------------------
  // Stage 1: operand, zero flag, leading-one index
  // ---------------------------------------------------------------------------
  logic [IN_W-1:0] s1_data_q, s1_data_d;
  logic            s1_zero_q, s1_zero_d;
  logic [KW-1:0]   s1_k_q, s1_k_d, k_enc;

  // Priority encoder: the highest set bit wins because it is visited last.
  always_comb begin
    k_enc = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (in_data[i]) k_enc = KW'(i);
    end
  end

  always_comb begin
    s1_data_d = s1_data_q;
    s1_zero_d = s1_zero_q;
    s1_k_d    = s1_k_q;
    if (in_valid && in_ready) begin
      s1_data_d = in_data;
      s1_zero_d = (in_data == '0);
      s1_k_d    = k_enc;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: normalize, round, assemble
  // ---------------------------------------------------------------------------
  logic [31:0] norm;
  logic        guard, sticky, round_up;
  logic [7:0]  exp_m1;
  logic [31:0] fp_rnd;
  logic [31:0] fp_q, fp_d;
  logic        inexact_q, inexact_d;

  // Leading one lands on bit 31; bits [30:8] are the fraction, bit 7 the
  // guard, bits [6:0] the sticky. For k <= 23 the low byte is all zero, so
  // the exact case needs no separate path.
  assign norm     = 32'(s1_data_q) << (5'd31 - 5'(s1_k_q));
  assign guard    = norm[7];
  assign sticky   = |norm[6:0];
  assign round_up = guard & (sticky | norm[8]);
  assign exp_m1   = 8'(s1_k_q) + EXP_M1;
  assign fp_rnd   = {1'b0, exp_m1, 23'd0} + {8'd0, norm[31:8]} + {31'd0, round_up};

  always_comb begin
    fp_d      = fp_q;
    inexact_d = inexact_q;
    if (s2_load && vld_pipe_q[1]) begin
      fp_d      = s1_zero_q ? 32'd0 : fp_rnd;
      inexact_d = !s1_zero_q && (guard || sticky);
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      s1_data_q  <= '0;
      s1_zero_q  <= 1'b0;
      s1_k_q     <= '0;
      fp_q       <= '0;
      inexact_q  <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_data_q  <= s1_data_d;
      s1_zero_q  <= s1_zero_d;
      s1_k_q     <= s1_k_d;
      fp_q       <= fp_d;
      inexact_q  <= inexact_d;
    end
  end

  assign out_valid   = vld_pipe_q[2];
  assign out_fp32    = fp_q;
  assign out_inexact = inexact_q;

endmodule

// File: tb/tb_ufix_to_fp32_pipe.sv
// Bench for ufix_to_fp32_pipe: four instances with different IN_W/FRAC_W
// share one handshake, each checked against an arithmetic reference model.
module tb_ufix_to_fp32_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] d0 = '0, d2 = '0;
  logic [15:0] d1 = '0, d3 = '0;
  logic [3:0]  ir, ov, oi;
  logic [3:0][31:0] of;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic strict = 1'b0;
  logic rnd_done;

  typedef struct packed {
    logic [3:0][31:0] fp;
    logic [3:0]       inx;
    int               cyc;
    logic             lat;
  } exp_t;
  exp_t q[$];

  string lname[4] = '{"u32f16", "u16f8", "u32f0", "u16f16"};

  ufix_to_fp32_pipe #(.IN_W(32), .FRAC_W(16)) u0 (.clk(clk), .rst_n(rst_n), .in_data(d0),
    .in_valid(in_valid), .in_ready(ir[0]), .out_fp32(of[0]), .out_inexact(oi[0]),
    .out_valid(ov[0]), .out_ready(out_ready));
  ufix_to_fp32_pipe #(.IN_W(16), .FRAC_W(8)) u1 (.clk(clk), .rst_n(rst_n), .in_data(d1),
    .in_valid(in_valid), .in_ready(ir[1]), .out_fp32(of[1]), .out_inexact(oi[1]),
    .out_valid(ov[1]), .out_ready(out_ready));
  ufix_to_fp32_pipe #(.IN_W(32), .FRAC_W(0)) u2 (.clk(clk), .rst_n(rst_n), .in_data(d2),
    .in_valid(in_valid), .in_ready(ir[2]), .out_fp32(of[2]), .out_inexact(oi[2]),
    .out_valid(ov[2]), .out_ready(out_ready));
  ufix_to_fp32_pipe #(.IN_W(16), .FRAC_W(16)) u3 (.clk(clk), .rst_n(rst_n), .in_data(d3),
    .in_valid(in_valid), .in_ready(ir[3]), .out_fp32(of[3]), .out_inexact(oi[3]),
    .out_valid(ov[3]), .out_ready(out_ready));

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: value x * 2^-f rounded to 24 significant bits, RNE.
  function automatic logic [32:0] ref_cvt(input longint unsigned x, input int f);
    longint unsigned t, mant, rem, half;
    int   k, e, sh;
    logic inx;
    if (x == 0) return 33'd0;
    t = x;
    k = -1;
    while (t != 0) begin t = t >> 1; k++; end
    inx = 1'b0;
    if (k <= 23) begin
      mant = x << (23 - k);
    end else begin
      sh   = k - 23;
      mant = x >> sh;
      rem  = x - (mant << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && mant[0])) mant++;
      inx = (rem != 0);
    end
    e = k - f + 127;
    if (mant == (64'd1 << 24)) begin mant = mant >> 1; e++; end
    return {inx, 1'b0, e[7:0], mant[22:0]};
  endfunction

  task automatic chk(input string name, input logic [131:0] act, input logic [131:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  // Compare process: scoreboard push on input transfer, pop/compare on output
  // transfer, and hold check while the output is stalled.
  initial begin : cmp
    exp_t e;
    logic stall_prev;
    logic [3:0][31:0] of_prev;
    logic [3:0] oi_prev;
    logic [32:0] r0, r1, r2, r3;
    stall_prev = 1'b0;
    of_prev = '0;
    oi_prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        stall_prev = 1'b0;
      end else begin
        if (stall_prev)
          chk("hold_while_stalled", {ov, oi, of}, {4'hF, oi_prev, of_prev});
        if (ov[0] && out_ready) begin
          chk("lane_valid_agree", ov, 4'hF);
          if (q.size() == 0) begin
            chk("spurious_output", {oi, of}, 132'd0 - 1);
          end else begin
            e = q.pop_front();
            for (int l = 0; l < 4; l++)
              chk(lname[l], {oi[l], of[l]}, {e.inx[l], e.fp[l]});
            if (e.lat) chk("latency", cyc - e.cyc, 2);
          end
        end
        stall_prev = ov[0] && !out_ready;
        of_prev = of;
        oi_prev = oi;
        if (in_valid && ir[0]) begin
          r0 = ref_cvt(d0, 16);
          r1 = ref_cvt({48'd0, d1}, 8);
          r2 = ref_cvt(d2, 0);
          r3 = ref_cvt({48'd0, d3}, 16);
          e.fp  = {r3[31:0], r2[31:0], r1[31:0], r0[31:0]};
          e.inx = {r3[32], r2[32], r1[32], r0[32]};
          e.cyc = cyc;
          e.lat = strict;
          q.push_back(e);
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [15:0] b,
                      input logic [31:0] c, input logic [15:0] d);
    int n;
    logic acc;
    d0 = a; d1 = b; d2 = c; d3 = d;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      acc = ir[0];
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) fail_now("send");
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || ov[0]) && n < 500) begin @(posedge clk); #1; n++; end
    if (n >= 500) fail_now("drain");
  endtask

  function automatic logic [31:0] rnd32();
    return $urandom >> $urandom_range(0, 31);
  endfunction

  initial begin : main
    // Reset state
    cycles(3);
    chk("rst_out_valid", ov, 4'h0);
    chk("rst_out_fp32", of, 128'd0);
    chk("rst_out_inexact", oi, 4'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", ir, 4'hF);
    @(posedge clk); #1;

    // Hand-computed values pinning the model
    chk("model_8000_q16", ref_cvt(64'h8000, 16), 33'h0_3F00_0000);
    chk("model_0001_q16", ref_cvt(64'h0001, 16), 33'h0_3780_0000);
    chk("model_tie_even", ref_cvt(64'h0100_0001, 16), 33'h1_4380_0000);
    chk("model_tie_odd", ref_cvt(64'h0100_0003, 16), 33'h1_4380_0002);
    chk("model_carry", ref_cvt(64'hFFFF_FFFF, 0), 33'h1_4F80_0000);
    chk("model_zero", ref_cvt(64'h0, 0), 33'h0_0000_0000);
    chk("model_1p5_q8", ref_cvt(64'h0180, 8), 33'h0_3FC0_0000);

    // Directed vectors, out_ready held 1, exact latency checked
    strict = 1'b1;
    send(32'h0100_0001, 16'h0180, 32'hFFFF_FFFF, 16'h8000);
    send(32'h0100_0003, 16'h0000, 32'h0000_0000, 16'h0001);
    send(32'h00FF_FFFF, 16'hFFFF, 32'h0100_0000, 16'h0000);
    send(32'h01FF_FFFF, 16'h0001, 32'h8000_0080, 16'hFFFF);
    send(32'h0000_0000, 16'h8000, 32'h8000_0180, 16'h1234);
    drain();

    // Eight back-to-back inputs, out_ready low for cycles 3..6
    strict = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(32'h0111_1111 * (i + 1) + 1, 16'(i * 4097 + 3), 32'hF000_0001 >> i, 16'(1 << (2 * i)));
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(negedge clk);
        chk("stall_in_ready_low", ir, 4'h0);
        chk("stall_out_valid", ov, 4'hF);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Random gaps and random backpressure
    rnd_done = 1'b0;
    fork
      begin
        repeat (300) begin
          cycles($urandom_range(0, 2));
          send(rnd32(), 16'(rnd32()), rnd32(), 16'(rnd32()));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two operands in flight
    out_ready = 1'b0;
    send(32'h1234_5678, 16'h00AB, 32'h0000_0003, 16'h4000);
    send(32'h0000_0010, 16'h0010, 32'h0000_0010, 16'h0010);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", ov, 4'h0);
    chk("midrst_out_fp32", of, 128'd0);
    cycles(2);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("in_ready_after_midrst", ir, 4'hF);
    @(posedge clk); #1;
    cycles(5);
    strict = 1'b1;
    send(32'h0100_0003, 16'h0101, 32'hFFFF_FFFF, 16'h8000);
    drain();

    // Exhaustive 16-bit sweep (lanes u16f8 and u16f16), back to back
    for (int i = 0; i < 65536; i++)
      send($urandom, 16'(i), rnd32(), 16'(i));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
